// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed hex display scanner with frame-synchronous double buffering, PWM brightness, leading-zero blanking and selectable polarity
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BRIGHT_BITS  = 3,
  parameter int COMMON_ANODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic                    blank,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP = SCAN_DIV >> BRIGHT_BITS;
  localparam logic OFF = COMMON_ANODE != 0;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx;
  logic [BRIGHT_BITS-1:0]  r_bright;
  logic [4*NUM_DIGITS-1:0] r_stage, r_shadow;
  logic [NUM_DIGITS-1:0]   r_stage_dp, r_shadow_dp;
  logic                    r_pending;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_frame_done;
  logic                    w_slot_end, w_boundary, w_lit, w_sup, w_on, w_upper_zero;
  logic [BRIGHT_BITS-1:0]  w_bright;
  logic [31:0]             w_on_len;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_dig;
  always_comb begin
    w_slot_end   = r_pre == PW'(SCAN_DIV - 1);
    w_boundary   = w_slot_end && r_idx == IW'(NUM_DIGITS - 1);
    // brightness is latched at the slot start so a mid-slot change cannot chop the current pulse
    w_bright     = r_pre == '0 ? brightness : r_bright;
    w_on_len     = (32'(w_bright) + 32'd1) * 32'(STEP);
    w_lit        = 32'(r_pre) < w_on_len;
    w_nib        = r_shadow[4*r_idx +: 4];
    // this digit and everything above it is zero
    w_upper_zero = (r_shadow >> (4*r_idx)) == '0;
    w_sup        = lz_en && r_idx != '0 && !r_shadow_dp[r_idx] && w_upper_zero;
    w_on         = !blank && w_lit && !w_sup;
    w_seg        = w_on ? SEG_LUT[w_nib] : 7'h00;
    w_dig        = w_on ? NUM_DIGITS'(1) << r_idx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_bright     <= '0;
      r_stage      <= '0;
      r_stage_dp   <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_seg        <= {7{OFF}};
      r_dp         <= OFF;
      r_dig        <= {NUM_DIGITS{OFF}};
      r_frame_done <= 1'b0;
    end else begin
      r_pre    <= w_slot_end ? '0 : r_pre + PW'(1);
      r_bright <= w_bright;
      if (w_slot_end)
        r_idx <= r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + IW'(1);
      if (load) begin
        r_stage    <= digit_data;
        r_stage_dp <= dp_in;
      end
      // a load landing on the boundary bypasses staging so it is shown in the very next frame
      if (w_boundary) begin
        if (load) begin
          r_shadow    <= digit_data;
          r_shadow_dp <= dp_in;
        end else if (r_pending) begin
          r_shadow    <= r_stage;
          r_shadow_dp <= r_stage_dp;
        end
        r_pending <= 1'b0;
      end else if (load)
        r_pending <= 1'b1;
      r_seg        <= w_seg ^ {7{OFF}};
      r_dp         <= (w_on && r_shadow_dp[r_idx]) ^ OFF;
      r_dig        <= w_dig ^ {NUM_DIGITS{OFF}};
      r_frame_done <= w_boundary;
    end
  end
  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign dig_en     = r_dig;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboard bench comparing two polarities of the scanner against a frame-level reference model
module tb_seven_seg_scan_driver;
  localparam int N = 4;
  localparam int S = 16;
  localparam int BB = 2;
  localparam int FR = N * S;
  logic clk = 1'b0;
  logic rst, load, lz_en, blank;
  logic [15:0] digit_data;
  logic [3:0] dp_in;
  logic [1:0] brightness;
  logic [6:0] a_seg, b_seg;
  logic a_dp, b_dp, a_fd, b_fd;
  logic [3:0] a_dig, b_dig;
  always #5 clk = ~clk;
  seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BRIGHT_BITS(BB), .COMMON_ANODE(0)) u_cc (
    .clk(clk), .rst(rst), .digit_data(digit_data), .dp_in(dp_in), .load(load), .lz_en(lz_en),
    .blank(blank), .brightness(brightness), .seg_out(a_seg), .dp_out(a_dp), .dig_en(a_dig), .frame_done(a_fd)
  );
  seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BRIGHT_BITS(BB), .COMMON_ANODE(1)) u_ca (
    .clk(clk), .rst(rst), .digit_data(digit_data), .dp_in(dp_in), .load(load), .lz_en(lz_en),
    .blank(blank), .brightness(brightness), .seg_out(b_seg), .dp_out(b_dp), .dig_en(b_dig), .frame_done(b_fd)
  );
  typedef struct {
    logic [12:0] e_cc;
    logic [12:0] e_ca;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_t = 0;
  int m_bright = 0;
  logic [15:0] m_shadow = '0, m_pv = '0;
  logic [3:0] m_sdp = '0, m_pdp = '0;
  bit m_pend = 0;
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({a_seg, a_dp, a_dig, a_fd} !== e.e_cc) begin
        n_fail++;
        $display("FAIL cc_out cyc %0d got %h expected %h", e.cyc, {a_seg, a_dp, a_dig, a_fd}, e.e_cc);
      end
      n_checks++;
      if ({b_seg, b_dp, b_dig, b_fd} !== e.e_ca) begin
        n_fail++;
        $display("FAIL ca_out cyc %0d got %h expected %h", e.cyc, {b_seg, b_dp, b_dig, b_fd}, e.e_ca);
      end
    end
  end
  task automatic step();
    exp_t e;
    int pre, idx, on_len;
    bit on, sup;
    logic [15:0] sh;
    logic [6:0] sg;
    logic d, fd;
    logic [3:0] dg;
    sg = '0; d = 1'b0; dg = '0; fd = 1'b0;
    if (rst) begin
      m_t = 0; m_shadow = '0; m_sdp = '0; m_pend = 0;
    end else begin
      pre = m_t % S;
      idx = (m_t / S) % N;
      if (pre == 0) m_bright = int'(brightness);
      on_len = (m_bright + 1) * (S >> BB);
      sh = m_shadow >> (4 * idx);
      sup = lz_en && idx != 0 && !m_sdp[idx] && sh == 16'h0;
      on = !blank && pre < on_len && !sup;
      if (on) begin
        sg = lut[sh[3:0]];
        d = m_sdp[idx];
        dg = 4'(1 << idx);
      end
      fd = (m_t % FR) == FR - 1;
      if (fd) begin
        if (load) begin m_shadow = digit_data; m_sdp = dp_in; end
        else if (m_pend) begin m_shadow = m_pv; m_sdp = m_pdp; end
        m_pend = 0;
      end else if (load) begin
        m_pend = 1; m_pv = digit_data; m_pdp = dp_in;
      end
      m_t++;
    end
    e.e_cc = {sg, d, dg, fd};
    e.e_ca = {~sg, ~d, ~dg, fd};
    e.cyc = cyc;
    sb.push_back(e);
    cyc++;
    @(negedge clk);
    #1;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic to_pos(input int p);
    for (int i = 0; i < FR && (m_t % FR) != p; i++) step();
  endtask
  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    digit_data = v; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask
  initial begin
    rst = 1'b1; load = 1'b1; digit_data = 16'hFFFF; dp_in = '0;
    lz_en = 1'b0; blank = 1'b0; brightness = 2'd3;
    @(negedge clk);
    #1;
    run(5);
    rst = 1'b0; load = 1'b0;
    run(70);
    pulse_load(16'h1234, 4'b0000);
    run(140);
    brightness = 2'd1;
    run(70);
    to_pos(16 + 5);
    brightness = 2'd3;
    run(30);
    brightness = 2'd0;
    run(40);
    brightness = 2'd3;
    lz_en = 1'b1;
    pulse_load(16'h0045, 4'b0000);
    run(130);
    pulse_load(16'h0000, 4'b0000);
    run(130);
    pulse_load(16'h0045, 4'b0100);
    run(130);
    lz_en = 1'b0;
    to_pos(20);
    pulse_load(16'hABCD, 4'b0000);
    to_pos(40);
    pulse_load(16'hEEEE, 4'b0000);
    run(70);
    to_pos(FR - 1);
    pulse_load(16'h5678, 4'b1001);
    run(20);
    blank = 1'b1;
    run(20);
    blank = 1'b0;
    to_pos(2 * S + 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(80);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      load = ($urandom_range(0, 19) == 0);
      digit_data = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
      blank = ($urandom_range(0, 29) == 0);
      brightness = 2'($urandom);
      step();
    end
    rst = 1'b0; load = 1'b0; blank = 1'b0;
    run(FR + 2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
